cabac_byte_feeder: RTL and testbench

Bitstream byte-supply stage sitting directly upstream of the bitsNeeded/renormalisation logic in the VVC arithmetic decoder. Buffers incoming slice-data bytes in a small show-ahead FIFO and performs the 2-byte initial value load after start. During decoding it hands one byte to the value register each cycle that bitsNeeded raises request_byte. Signals a stall when a byte is requested but none is buffered.

---
 rtl/cabac_byte_feeder.sv | 129 ++++++++++++
 tb/tb_cabac_byte_feeder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cabac_byte_feeder.sv
// Byte-supply stage for the VVC arithmetic decoder: show-ahead FIFO, 2-byte init load, per-request pop.
// Optional BYTE_FEEDER_CNT_EN adds a 32-bit consumed_bytes counter output.
module cabac_byte_feeder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             request_byte,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic             stall,
  output logic [15:0]      init_value,
  output logic             init_done,
`ifdef BYTE_FEEDER_CNT_EN
  output logic [31:0]      consumed_bytes,
`endif
  output logic [CNT_W-1:0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

  typedef enum logic [1:0] {StIdle, StInit0, StInit1, StRun} state_e;

  state_e           state_q, state_d;
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [15:0]      init_value_q;
  logic             init_done_q;
  logic             push, pop, empty;

  assign empty      = (count_q == '0);
  assign in_ready   = (count_q < DepthCnt);
  // flush wins over every other request in the same cycle
  assign push       = in_valid && in_ready && !flush;
  assign pop        = !flush && !empty &&
                      ((state_q == StInit0) || (state_q == StInit1) ||
                       ((state_q == StRun) && request_byte));
  assign byte_out   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign byte_valid = (state_q == StRun) && !empty;
  assign stall      = (state_q == StRun) && request_byte && empty;
  assign level      = count_q;
  assign init_value = init_value_q;
  assign init_done  = init_done_q;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (start) state_d = StInit0;
        StInit0: if (pop) state_d = StInit1;
        StInit1: if (pop) state_d = StRun;
        StRun:   state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage needs no reset; the count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_value_q <= '0;
      init_done_q  <= 1'b0;
    end else begin
      init_done_q <= pop && (state_q == StInit1);
      if (pop && (state_q == StInit0)) init_value_q[15:8] <= byte_out;
      if (pop && (state_q == StInit1)) init_value_q[7:0]  <= byte_out;
    end
  end

`ifdef BYTE_FEEDER_CNT_EN
  logic [31:0] consumed_q;
  assign consumed_bytes = consumed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      consumed_q <= '0;
    end else if (flush) begin
      consumed_q <= '0;
    end else if (pop) begin
      consumed_q <= consumed_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cabac_byte_feeder.sv
// Scoreboard bench for cabac_byte_feeder: expected bytes/init values queued, monitor compares on output.
module tb_cabac_byte_feeder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             flush = 1'b0;
  logic [7:0]       in_byte = 8'h00;
  logic             in_valid = 1'b0;
  logic             request_byte = 1'b0;
  logic             in_ready;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             stall;
  logic [15:0]      init_value;
  logic             init_done;
  logic [CNT_W-1:0] level;
`ifdef BYTE_FEEDER_CNT_EN
  logic [31:0]      consumed_bytes;
`endif

  cabac_byte_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .flush        (flush),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .request_byte (request_byte),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .stall        (stall),
    .init_value   (init_value),
    .init_done    (init_done),
`ifdef BYTE_FEEDER_CNT_EN
    .consumed_bytes (consumed_bytes),
`endif
    .level        (level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0]  byte_q [$];
  logic [15:0] init_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: compare whenever the DUT presents an init result or a consumed byte.
  always @(negedge clk) begin
    if (rst_n && init_done) begin
      if (init_q.size() == 0) check("unexpected_init_done", 32'd1, 32'd0);
      else check("init_value", {16'h0, init_value}, {16'h0, init_q.pop_front()});
    end
    if (rst_n && byte_valid && request_byte) begin
      if (byte_q.size() == 0) check("unexpected_byte", {24'h0, byte_out}, 32'hFFFF_FFFF);
      else check("byte_out", {24'h0, byte_out}, {24'h0, byte_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1;
    check("rst_level", 32'(level), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_byte_valid", 32'(byte_valid), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_byte_out", 32'(byte_out), 0);
    check("rst_init_value", 32'(init_value), 0);
    check("rst_init_done", 32'(init_done), 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Init load
    push1(8'h9A);
    push1(8'h3C);
    push1(8'h55);
    check("idle_level", 32'(level), 3);
    check("idle_byte_valid", 32'(byte_valid), 0);
    check("idle_head", 32'(byte_out), 32'h9A);
    init_q.push_back(16'h9A3C);
    start = 1'b1;
    step();
    start = 1'b0;
    check("init0_done", 32'(init_done), 0);
    check("init0_level", 32'(level), 3);
    step();
    check("init1_done", 32'(init_done), 0);
    check("init1_level", 32'(level), 2);
    step();
    check("init_done_pulse", 32'(init_done), 1);
    check("run_level", 32'(level), 1);
    check("run_head", 32'(byte_out), 32'h55);
    check("run_byte_valid", 32'(byte_valid), 1);
    byte_q.push_back(8'h55);
    request_byte = 1'b1;
    step();
    request_byte = 1'b0;
    check("init_done_one_cycle", 32'(init_done), 0);
    check("drain_level", 32'(level), 0);

    // Fill to full, rejected push, drain in order
    for (int i = 1; i <= 4; i++) push1(8'(i));
    check("full_in_ready", 32'(in_ready), 0);
    check("full_level", 32'(level), 4);
    in_valid = 1'b1;
    in_byte  = 8'hFF;
    step();
    in_valid = 1'b0;
    check("full_reject_level", 32'(level), 4);
    for (int i = 1; i <= 4; i++) byte_q.push_back(8'(i));
    request_byte = 1'b1;
    repeat (4) step();
    request_byte = 1'b0;
    check("empty_byte_valid", 32'(byte_valid), 0);
    check("empty_level", 32'(level), 0);
    check("empty_in_ready", 32'(in_ready), 1);

    // Stall on empty
    request_byte = 1'b1;
    #1;
    check("stall_on", 32'(stall), 1);
    step();
    check("stall_hold", 32'(stall), 1);
    check("stall_level", 32'(level), 0);
    push1(8'hE7);
    check("stall_clear", 32'(stall), 0);
    check("stall_head", 32'(byte_out), 32'hE7);
    check("stall_byte_valid", 32'(byte_valid), 1);
    byte_q.push_back(8'hE7);
    step();
    request_byte = 1'b0;
    check("stall_pop_level", 32'(level), 0);

    // Push/pop at full with pointer wrap
    push1(8'hA0);
    push1(8'hA1);
    push1(8'hA2);
    push1(8'hA3);
    byte_q.push_back(8'hA0);
    byte_q.push_back(8'hA1);
    byte_q.push_back(8'hA2);
    byte_q.push_back(8'hA3);
    byte_q.push_back(8'hB0);
    request_byte = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'hB0;
    #1;
    check("wrap_full_ready", 32'(in_ready), 0);
    step();
    check("wrap_pop_only_level", 32'(level), 3);
    step();
    in_valid = 1'b0;
    check("wrap_push_pop_level", 32'(level), 3);
    repeat (3) step();
    request_byte = 1'b0;
    check("wrap_drain_level", 32'(level), 0);

    // Flush priority over start and push
    push1(8'hC1);
    push1(8'hC2);
    check("pre_flush_level", 32'(level), 2);
    flush    = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'hD0;
    step();
    flush    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    check("flush_level", 32'(level), 0);
    check("flush_byte_valid", 32'(byte_valid), 0);
    check("flush_init_value", 32'(init_value), 32'h9A3C);
`ifdef BYTE_FEEDER_CNT_EN
    check("flush_consumed", consumed_bytes, 0);
`endif
    request_byte = 1'b1;
    push1(8'hE1);
    check("idle_req_stall", 32'(stall), 0);
    check("idle_req_valid", 32'(byte_valid), 0);
    check("idle_req_level", 32'(level), 1);
    check("flush_dropped_push", 32'(byte_out), 32'hE1);
    push1(8'hE2);
    request_byte = 1'b0;
    step();
    step();
    check("idle_needs_start", 32'(level), 2);
    init_q.push_back(16'hE1E2);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("reinit_done", 32'(init_done), 1);
    check("reinit_level", 32'(level), 0);

    // Asynchronous reset mid-run
    push1(8'hF1);
    push1(8'hF2);
    push1(8'hF3);
    check("pre_rst_level", 32'(level), 3);
    check("pre_rst_valid", 32'(byte_valid), 1);
    rst_n = 1'b0;
    #1;
    check("arst_level", 32'(level), 0);
    check("arst_byte_valid", 32'(byte_valid), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_byte_out", 32'(byte_out), 0);
    step();
    rst_n = 1'b1;
    step();
    push1(8'hF4);
    request_byte = 1'b1;
    #1;
    check("post_rst_valid", 32'(byte_valid), 0);
    check("post_rst_stall", 32'(stall), 0);
    step();
    request_byte = 1'b0;
    check("post_rst_level", 32'(level), 1);
`ifdef BYTE_FEEDER_CNT_EN
    check("post_rst_consumed", consumed_bytes, 0);
`endif

    check("byte_q_drained", byte_q.size(), 0);
    check("init_q_drained", init_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
